// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word read at a time from instruction
// memory, holds the returned word for the decode stage until it is consumed,
// then advances the PC sequentially or to a branch target.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr,
  output logic [5:0]  opCode,
  output logic [5:0]  func,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4
);

  localparam logic [1:0] IDLE_RST = 2'd0;
  localparam logic [1:0] REQ      = 2'd1;
  localparam logic [1:0] HOLD     = 2'd2;

  // The low two bits are forced to zero so the fetch address is always word aligned.
  localparam logic [31:0] ALIGNED_RESET_PC = {RESET_PC[31:2], 2'b00};

  logic [1:0]  state;
  logic [1:0]  stateNext;
  logic [31:0] pc;
  logic [31:0] pcNext;
  logic [31:0] instrReg;
  logic [31:0] pcInc;
  logic [31:0] branchAddr;
  logic        consume;

  assign pcInc      = pc + 32'd4;
  assign branchAddr = branch_target & 32'hFFFF_FFFC;
  assign consume    = (state == HOLD) && !stall;

  // Next-state and next-PC selection; branch_taken only matters on a consume.
  always_comb begin
    stateNext = state;
    pcNext    = pc;
    case (state)
      IDLE_RST: stateNext = REQ;
      REQ: begin
        if (imem_ack) begin
          stateNext = HOLD;
        end
      end
      HOLD: begin
        if (consume) begin
          stateNext = REQ;
          pcNext    = branch_taken ? branchAddr : pcInc;
        end
      end
      default: stateNext = IDLE_RST;
    endcase
  end

  // State and PC registers; reset takes effect immediately and drops any in-flight ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE_RST;
      pc    <= ALIGNED_RESET_PC;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
    end
  end

  // Capture the returned word on the acknowledging edge of a request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instrReg <= 32'h0;
    end else if ((state == REQ) && imem_ack) begin
      instrReg <= imem_rdata;
    end
  end

  assign imem_req    = (state == REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == HOLD);
  assign instr       = instrReg;
  assign opCode      = instrReg[31:26];
  assign func        = instrReg[5:0];
  assign pc_out      = pc;
  assign pc_plus4    = pcInc;

endmodule
